adaptive_filter_feeder: RTL and testbench
=========================================

Name: adaptive_filter_feeder

Overview:
- Upstream source for the adaptive filter: accepts samples over a valid/ready stream, buffers them, and emits one 14-bit sample per clock on the filter's free-running input (no backpressure).
- Owns the filter mode line (1 = integrator, 0 = differentiator).
- On a mode change it stops popping and feeds zeros so the filter delay line and feedback loop flush before ctrl toggles.
- Marks filler (zero) samples so downstream can discard them.

Parameters:
- DATA_WIDTH, 14, sample width; must match the filter input.
- FIFO_DEPTH, 16, input buffer depth in samples; power of two, at least 4.
- FLUSH_LEN, 8, zero samples fed before a mode switch; must be at least filter order + feedback delay.
- INIT_MODE, 0, flt_ctrl value after reset.

Ports:
- clk, input, 1, clock.
- srst, input, 1, synchronous reset, active-high.
- s_tdata, input, DATA_WIDTH, input sample.
- s_tvalid, input, 1, input sample valid.
- s_tready, output, 1, feeder can accept a sample.
- mode_req, input, 1, requested mode (1 = integrator, 0 = differentiator).
- mode_req_valid, input, 1, single-cycle request strobe.
- mode_busy, output, 1, flush/switch in progress; requests ignored.
- flt_tdata, output, DATA_WIDTH, sample to the filter's s_tdata.
- flt_tvalid, output, 1, 1 = real sample, 0 = filler zero.
- flt_ctrl, output, 1, filter mode to the filter's ctrl.
- underrun_cnt, output, 16, saturating count of filler cycles caused by an empty FIFO while in RUN.

Behaviour:
- Reset values:
  - flt_tdata = 0, flt_tvalid = 0, flt_ctrl = INIT_MODE, mode_busy = 0, underrun_cnt = 0.
  - FIFO empty, s_tready = 1 from the first cycle after reset, FSM in RUN.
- Reset mid-operation: all of the above apply on the next edge; FIFO contents and any pending flush are discarded.
- Input handshake:
  - A push occurs when s_tvalid and s_tready are both high at the edge.
  - s_tready = !full, derived from a registered occupancy count; it does not depend combinationally on s_tvalid.
  - Simultaneous push and pop are allowed and leave occupancy unchanged.
  - When full, s_tready = 0 even if a pop happens the same cycle.
- Output side:
  - flt_tdata, flt_tvalid and flt_ctrl are registered and update every cycle.
  - Minimum latency: a sample pushed at edge N into an empty FIFO appears on flt_tdata after edge N+1.
- FSM states:
  - RUN:
    - FIFO not empty: pop one sample per cycle; flt_tdata = head, flt_tvalid = 1.
    - FIFO empty: flt_tdata = 0, flt_tvalid = 0, underrun_cnt increments, saturating at 0xFFFF.
    - mode_req_valid with mode_req != flt_ctrl: go to DRAIN, load the counter with FLUSH_LEN-1, set mode_busy = 1.
    - mode_req_valid with mode_req == flt_ctrl: ignored, no flush.
  - DRAIN:
    - No pops; flt_tdata = 0, flt_tvalid = 0; underrun_cnt does not count.
    - Counter decrements each cycle; when it reaches 0, go to SWITCH.
    - Pushes continue while s_tready is high.
  - SWITCH:
    - One cycle: flt_ctrl <= latched requested mode; output is a zero filler.
    - Then go to RUN; mode_busy = 0 from the first RUN cycle.
  - The total flush is FLUSH_LEN zero outputs in DRAIN plus 1 in SWITCH.
- Requests: mode_req_valid while mode_busy = 1 is dropped, with no queueing. The requested mode is latched on acceptance.
- Arithmetic:
  - Samples pass through unmodified.
  - FIFO pointers are log2(FIFO_DEPTH) bits and wrap modulo the depth.
  - The occupancy counter is log2(FIFO_DEPTH)+1 bits.

Optional Feature:
- Macro: ADAPTIVE_FILTER_FEEDER_DITHER_EN.
- When defined:
  - A 16-bit Galois LFSR (polynomial x^16+x^14+x^13+x^11+1, seed 0xACE1 on reset) advances every cycle.
  - Filler outputs in RUN-underrun, DRAIN and SWITCH carry LFSR[1:0] sign-extended to DATA_WIDTH (values -2..1) instead of 0.
  - flt_tvalid remains 0 for these outputs.
- When not defined: fillers are exactly 0 and no LFSR is instantiated.

Test Plan:
- Reset, then push 1,2,3 on consecutive cycles → flt_tdata = 1,2,3 with flt_tvalid = 1 starting 2 cycles after the first push; underrun_cnt counts the idle cycles before it.
- Hold s_tvalid = 1 with FIFO_DEPTH = 16 while a mode switch holds off pops → s_tready falls after 16 accepted samples; no sample lost or duplicated; order preserved after resume.
- From INIT_MODE = 0, pulse mode_req = 1 with FIFO holding 5 samples:
  - mode_busy high for 9 cycles, output 9 zeros with flt_tvalid = 0.
  - flt_ctrl rises on the last zero.
  - The 5 samples then follow in order.
- mode_req = 0 while flt_ctrl = 0 → no busy, no zeros inserted, stream uninterrupted.
- Second request during DRAIN → ignored; flt_ctrl toggles once only.
- Assert srst mid-DRAIN with 7 samples buffered → next cycle: s_tready = 1, flt_tvalid = 0, flt_ctrl = INIT_MODE, underrun_cnt = 0, FIFO empty.

Source files
------------

// File: rtl/adaptive_filter_feeder.sv
// Stream buffer feeding the adaptive filter: FIFO, mode-switch flush FSM and filler marking.
// Optional build macro ADAPTIVE_FILTER_FEEDER_DITHER_EN replaces zero fillers with LFSR dither.
module adaptive_filter_feeder #(
    parameter int DATA_WIDTH = 14,
    parameter int FIFO_DEPTH = 16,
    parameter int FLUSH_LEN  = 8,
    parameter bit INIT_MODE  = 1'b0
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    input  logic                  mode_req,
    input  logic                  mode_req_valid,
    output logic                  mode_busy,
    output logic [DATA_WIDTH-1:0] flt_tdata,
    output logic                  flt_tvalid,
    output logic                  flt_ctrl,
    output logic [15:0]           underrun_cnt
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_SWITCH} state_t;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_reg;
    logic [PTR_W-1:0]      rd_ptr_reg;
    logic [PTR_W:0]        count_reg;
    state_t                state_reg;
    logic [CNT_W-1:0]      flush_cnt_reg;
    logic                  req_mode_reg;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] fill_value;

    // Ready comes only from the registered occupancy, so a same-cycle pop never reopens a full FIFO.
    assign s_tready = (count_reg != (PTR_W+1)'(FIFO_DEPTH));
    assign push     = s_tvalid && s_tready;
    assign pop      = (state_reg == ST_RUN) && (count_reg != '0);

`ifdef ADAPTIVE_FILTER_FEEDER_DITHER_EN
    logic [15:0] lfsr_reg;

    // Right-shifting Galois form of x^16+x^14+x^13+x^11+1.
    always_ff @(posedge clk) begin
        if (srst) begin
            lfsr_reg <= 16'hACE1;
        end else begin
            lfsr_reg <= (lfsr_reg >> 1) ^ (lfsr_reg[0] ? 16'hB400 : 16'h0000);
        end
    end

    assign fill_value = {{(DATA_WIDTH-2){lfsr_reg[1]}}, lfsr_reg[1:0]};
`else
    assign fill_value = '0;
`endif

    // Storage has no reset so it maps onto RAM; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= s_tdata;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            state_reg     <= ST_RUN;
            flush_cnt_reg <= '0;
            req_mode_reg  <= INIT_MODE;
            mode_busy     <= 1'b0;
            flt_tdata     <= '0;
            flt_tvalid    <= 1'b0;
            flt_ctrl      <= INIT_MODE;
            underrun_cnt  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase

            case (state_reg)
                ST_RUN: begin
                    if (pop) begin
                        flt_tdata  <= mem[rd_ptr_reg];
                        flt_tvalid <= 1'b1;
                    end else begin
                        flt_tdata  <= fill_value;
                        flt_tvalid <= 1'b0;
                        if (underrun_cnt != 16'hFFFF) begin
                            underrun_cnt <= underrun_cnt + 1'b1;
                        end
                    end
                    if (mode_req_valid && (mode_req != flt_ctrl)) begin
                        state_reg     <= ST_DRAIN;
                        flush_cnt_reg <= CNT_W'(FLUSH_LEN - 1);
                        req_mode_reg  <= mode_req;
                        mode_busy     <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    flt_tdata  <= fill_value;
                    flt_tvalid <= 1'b0;
                    if (flush_cnt_reg == '0) begin
                        state_reg <= ST_SWITCH;
                    end else begin
                        flush_cnt_reg <= flush_cnt_reg - 1'b1;
                    end
                end
                ST_SWITCH: begin
                    // Filter delay line is now flushed; toggle ctrl alongside the final filler.
                    flt_tdata  <= fill_value;
                    flt_tvalid <= 1'b0;
                    flt_ctrl   <= req_mode_reg;
                    mode_busy  <= 1'b0;
                    state_reg  <= ST_RUN;
                end
                default: begin
                    state_reg <= ST_RUN;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_adaptive_filter_feeder.sv
// Directed bench for adaptive_filter_feeder: vector table plus hand-written flush, backpressure and reset sequences.
module tb_adaptive_filter_feeder;
    logic        clk = 1'b0;
    logic        srst;
    logic [13:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic        mode_req;
    logic        mode_req_valid;
    logic        mode_busy;
    logic [13:0] flt_tdata;
    logic        flt_tvalid;
    logic        flt_ctrl;
    logic [15:0] underrun_cnt;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    adaptive_filter_feeder dut (
        .clk            (clk),
        .srst           (srst),
        .s_tdata        (s_tdata),
        .s_tvalid       (s_tvalid),
        .s_tready       (s_tready),
        .mode_req       (mode_req),
        .mode_req_valid (mode_req_valid),
        .mode_busy      (mode_busy),
        .flt_tdata      (flt_tdata),
        .flt_tvalid     (flt_tvalid),
        .flt_ctrl       (flt_ctrl),
        .underrun_cnt   (underrun_cnt)
    );

    typedef struct {
        logic        vld;
        logic [13:0] data;
        logic        exp_vld;
        logic [13:0] exp_data;
        logic [15:0] exp_urun;
    } vec_t;

    vec_t vecs [7];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passed++;
            $display("ok   %s act=%0h exp=%0h", name, act, exp);
        end else begin
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "timeout");
    end

    initial begin
        int          m;
        logic [13:0] nxt;
        logic [13:0] q[$];
        logic [13:0] exp_d;
        logic        exp_rdy;
        logic        run;
        logic        exp_pop;
        logic        do_push;

        // idle, idle, push 1, push 2, push 3, idle, idle
        vecs[0] = '{1'b0, 14'd0, 1'b0, 14'd0, 16'd1};
        vecs[1] = '{1'b0, 14'd0, 1'b0, 14'd0, 16'd2};
        vecs[2] = '{1'b1, 14'd1, 1'b0, 14'd0, 16'd3};
        vecs[3] = '{1'b1, 14'd2, 1'b1, 14'd1, 16'd3};
        vecs[4] = '{1'b1, 14'd3, 1'b1, 14'd2, 16'd3};
        vecs[5] = '{1'b0, 14'd0, 1'b1, 14'd3, 16'd3};
        vecs[6] = '{1'b0, 14'd0, 1'b0, 14'd0, 16'd4};

        srst = 1'b1; s_tdata = '0; s_tvalid = 1'b0; mode_req = 1'b0; mode_req_valid = 1'b0;
        step(); step();
        chk("rst_tready", 32'(s_tready), 32'd1);
        chk("rst_tvalid", 32'(flt_tvalid), 32'd0);
        chk("rst_tdata", 32'(flt_tdata), 32'd0);
        chk("rst_ctrl", 32'(flt_ctrl), 32'd0);
        chk("rst_busy", 32'(mode_busy), 32'd0);
        chk("rst_urun", 32'(underrun_cnt), 32'd0);
        srst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            s_tvalid = vecs[i].vld;
            s_tdata  = vecs[i].data;
            step();
            chk($sformatf("vec%0d_tvalid", i), 32'(flt_tvalid), 32'(vecs[i].exp_vld));
            chk($sformatf("vec%0d_tdata", i), 32'(flt_tdata), 32'(vecs[i].exp_data));
            chk($sformatf("vec%0d_urun", i), 32'(underrun_cnt), 32'(vecs[i].exp_urun));
        end
        s_tvalid = 1'b0;

        // Switch 0->1 with an empty FIFO, five samples pushed during the flush, stray request mid-drain
        mode_req = 1'b1; mode_req_valid = 1'b1;
        step();
        mode_req_valid = 1'b0;
        chk("swA_accept_busy", 32'(mode_busy), 32'd1);
        chk("swA_accept_urun", 32'(underrun_cnt), 32'd5);
        for (int k = 1; k <= 9; k++) begin
            s_tvalid       = (k <= 5);
            s_tdata        = 14'(10 + k - 1);
            mode_req_valid = (k == 3);
            mode_req       = 1'b0;
            step();
            mode_req_valid = 1'b0;
            chk($sformatf("swA%0d_tvalid", k), 32'(flt_tvalid), 32'd0);
            chk($sformatf("swA%0d_tdata", k), 32'(flt_tdata), 32'd0);
            chk($sformatf("swA%0d_busy", k), 32'(mode_busy), (k <= 8) ? 32'd1 : 32'd0);
            chk($sformatf("swA%0d_ctrl", k), 32'(flt_ctrl), (k == 9) ? 32'd1 : 32'd0);
        end
        chk("swA_urun_held", 32'(underrun_cnt), 32'd5);
        s_tvalid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("swA_out%0d_tvalid", k), 32'(flt_tvalid), 32'd1);
            chk($sformatf("swA_out%0d_tdata", k), 32'(flt_tdata), 32'(10 + k));
            chk($sformatf("swA_out%0d_ctrl", k), 32'(flt_ctrl), 32'd1);
        end
        step();
        chk("swA_tail_tvalid", 32'(flt_tvalid), 32'd0);
        chk("swA_tail_urun", 32'(underrun_cnt), 32'd6);

        // Request for the current mode: no busy, stream continues
        for (int k = 0; k < 5; k++) begin
            s_tvalid       = (k < 4);
            s_tdata        = 14'(20 + k);
            mode_req       = 1'b1;
            mode_req_valid = (k == 1);
            step();
            mode_req_valid = 1'b0;
            chk($sformatf("same%0d_busy", k), 32'(mode_busy), 32'd0);
            chk($sformatf("same%0d_tvalid", k), 32'(flt_tvalid), (k == 0) ? 32'd0 : 32'd1);
            if (k > 0) chk($sformatf("same%0d_tdata", k), 32'(flt_tdata), 32'(20 + k - 1));
        end
        chk("same_urun", 32'(underrun_cnt), 32'd7);
        chk("same_ctrl", 32'(flt_ctrl), 32'd1);
        s_tvalid = 1'b0;

        // Two switches with s_tvalid held: fill to 16, stall, then drain in order
        m = 0;
        nxt = 14'd100;
        for (int h = 0; h < 70; h++) begin
            mode_req_valid = (h == 0) || (h == 20);
            mode_req       = (h == 20);
            s_tvalid       = (h < 40);
            s_tdata        = nxt;
            exp_rdy        = (m != 16);
            chk($sformatf("bp%0d_tready", h), 32'(s_tready), 32'(exp_rdy));
            run     = !((h >= 1 && h <= 9) || (h >= 21 && h <= 29));
            exp_pop = run && (m > 0);
            do_push = s_tvalid && exp_rdy;
            step();
            mode_req_valid = 1'b0;
            exp_d = 14'd0;
            if (exp_pop) exp_d = q.pop_front();
            if (do_push) begin
                q.push_back(nxt);
                nxt = nxt + 14'd1;
            end
            m = m + (do_push ? 1 : 0) - (exp_pop ? 1 : 0);
            chk($sformatf("bp%0d_tvalid", h), 32'(flt_tvalid), 32'(exp_pop));
            if (exp_pop) chk($sformatf("bp%0d_tdata", h), 32'(flt_tdata), 32'(exp_d));
        end
        s_tvalid = 1'b0;
        chk("bp_end_ctrl", 32'(flt_ctrl), 32'd1);
        chk("bp_end_busy", 32'(mode_busy), 32'd0);
        chk("bp_end_tready", 32'(s_tready), 32'd1);

        // Reset in the middle of a drain with seven samples buffered
        mode_req = 1'b0; mode_req_valid = 1'b1;
        for (int k = 0; k < 7; k++) begin
            s_tvalid = 1'b1;
            s_tdata  = 14'(200 + k);
            step();
            mode_req_valid = 1'b0;
        end
        chk("mid_busy", 32'(mode_busy), 32'd1);
        srst = 1'b1; s_tvalid = 1'b0;
        step();
        chk("mrst_tready", 32'(s_tready), 32'd1);
        chk("mrst_tvalid", 32'(flt_tvalid), 32'd0);
        chk("mrst_ctrl", 32'(flt_ctrl), 32'd0);
        chk("mrst_urun", 32'(underrun_cnt), 32'd0);
        chk("mrst_busy", 32'(mode_busy), 32'd0);
        srst = 1'b0;
        step();
        chk("mrst_empty_tvalid", 32'(flt_tvalid), 32'd0);
        chk("mrst_empty_urun", 32'(underrun_cnt), 32'd1);
        s_tvalid = 1'b1; s_tdata = 14'd55;
        step();
        s_tvalid = 1'b0;
        chk("mrst_push_tvalid", 32'(flt_tvalid), 32'd0);
        step();
        chk("mrst_out_tvalid", 32'(flt_tvalid), 32'd1);
        chk("mrst_out_tdata", 32'(flt_tdata), 32'd55);
        step();
        chk("mrst_after_tvalid", 32'(flt_tvalid), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
